// File: rtl/ac97_slot_src.sv
// ac97_slot_src
//   Upstream feeder for the AC'97 frame serializer. After reset it idles for
//   WAIT_FRAMES frames (codec ready time), issues a fixed three-entry codec
//   register write sequence (one per frame), then streams PCM stereo pairs
//   from a small FIFO. Every payload output is registered and changes only on
//   the cycle after a frame_req pulse.
//
// Ports
//   i_bit_clk        AC'97 bit clock, sole clock
//   i_reset          asynchronous, active-high reset
//   i_frame_req      one-cycle pulse from serializer: load next frame payload
//   i_pcm_l_in       left sample (2's complement)
//   i_pcm_r_in       right sample (2's complement)
//   i_pcm_valid      sample pair offered; pushed when i_pcm_valid & o_pcm_ready
//   o_pcm_ready      FIFO not full
//   o_cmd_valid      slot0 tag bits for slot1/slot2
//   o_cmd_addr       slot1 codec register address (write, R/W bit = 0)
//   o_cmd_data       slot2 register write data
//   o_pcm_tag        slot0 tag bits for slot3/slot4
//   o_pcm_l_out      slot3 payload
//   o_pcm_r_out      slot4 payload
//   o_init_done      command sequence finished
//   o_underflow_cnt  frames in CMD/RUN with an empty FIFO, saturating at 255
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_WAIT | counting down codec-ready frames; FIFO fills, is not popped
// ST_CMD  | presenting one init command per frame, then entering RUN
// ST_RUN  | init finished; PCM streaming only, terminal until reset

module ac97_slot_src #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_FRAMES = 16
) (
  input  logic        i_bit_clk,
  input  logic        i_reset,
  input  logic        i_frame_req,
  input  logic [15:0] i_pcm_l_in,
  input  logic [15:0] i_pcm_r_in,
  input  logic        i_pcm_valid,
  output logic        o_pcm_ready,
  output logic        o_cmd_valid,
  output logic [6:0]  o_cmd_addr,
  output logic [15:0] o_cmd_data,
  output logic        o_pcm_tag,
  output logic [15:0] o_pcm_l_out,
  output logic [15:0] o_pcm_r_out,
  output logic        o_init_done,
  output logic [7:0]  o_underflow_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int WCW = $clog2(WAIT_FRAMES + 1);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_FRAMES - 1);
  localparam logic [1:0]     CMD_LAST_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_CMD  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // {addr[6:0], data[15:0]} for each init command
  function automatic logic [22:0] cmd_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    cmd_entry = {7'h02, 16'h0000};
      2'd1:    cmd_entry = {7'h04, 16'h0000};
      2'd2:    cmd_entry = {7'h18, 16'h0808};
      default: cmd_entry = '0;
    endcase
  endfunction

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]     r_cmd_idx, w_cmd_idx_nxt;

  logic           r_cmd_valid, w_cmd_valid_nxt;
  logic [6:0]     r_cmd_addr, w_cmd_addr_nxt;
  logic [15:0]    r_cmd_data, w_cmd_data_nxt;
  logic           r_pcm_tag, w_pcm_tag_nxt;
  logic [15:0]    r_pcm_l, w_pcm_l_nxt;
  logic [15:0]    r_pcm_r, w_pcm_r_nxt;
  logic           r_init_done, w_init_done_nxt;
  logic [7:0]     r_uf_cnt, w_uf_cnt_nxt;

  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic           w_empty, w_full, w_push, w_pop, w_pcm_slot;
  logic [31:0]    w_head;
  logic [22:0]    w_cmd_word;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Ready reflects the current FIFO state, so a pop in the same cycle does
  // not open a slot for a push until the following cycle.
  assign w_push     = i_pcm_valid & ~w_full;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  // r_cmd_idx is held at 0 throughout WAIT, so this also yields command 0
  // on the frame that leaves WAIT.
  assign w_cmd_word = cmd_entry(r_cmd_idx);

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_cmd_idx_nxt   = r_cmd_idx;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_data_nxt  = r_cmd_data;
    w_init_done_nxt = r_init_done;
    w_pcm_tag_nxt   = r_pcm_tag;
    w_pcm_l_nxt     = r_pcm_l;
    w_pcm_r_nxt     = r_pcm_r;
    w_uf_cnt_nxt    = r_uf_cnt;
    w_pcm_slot      = 1'b0;

    case (r_state)
      ST_WAIT: begin
        if (i_frame_req) begin
          if (r_wait_cnt == '0) begin
            w_state_nxt     = ST_CMD;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_addr_nxt  = w_cmd_word[22:16];
            w_cmd_data_nxt  = w_cmd_word[15:0];
            w_cmd_idx_nxt   = r_cmd_idx + 2'd1;
            w_pcm_slot      = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - WCW'(1);
          end
        end
      end
      ST_CMD: begin
        if (i_frame_req) begin
          w_pcm_slot = 1'b1;
          if (r_cmd_idx == CMD_LAST_DONE) begin
            w_state_nxt     = ST_RUN;
            w_cmd_valid_nxt = 1'b0;
            w_cmd_addr_nxt  = '0;
            w_cmd_data_nxt  = '0;
            w_init_done_nxt = 1'b1;
          end else begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_addr_nxt  = w_cmd_word[22:16];
            w_cmd_data_nxt  = w_cmd_word[15:0];
            w_cmd_idx_nxt   = r_cmd_idx + 2'd1;
          end
        end
      end
      ST_RUN: begin
        w_pcm_slot = i_frame_req;
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase

    // No bypass: a pair pushed in an empty-FIFO frame cycle waits a frame.
    w_pop = w_pcm_slot & ~w_empty;
    if (w_pcm_slot) begin
      if (!w_empty) begin
        w_pcm_tag_nxt = 1'b1;
        w_pcm_l_nxt   = w_head[31:16];
        w_pcm_r_nxt   = w_head[15:0];
      end else begin
        w_pcm_tag_nxt = 1'b0;
        w_pcm_l_nxt   = '0;
        w_pcm_r_nxt   = '0;
        if (r_uf_cnt != 8'hFF) begin
          w_uf_cnt_nxt = r_uf_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_bit_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_WAIT;
      r_wait_cnt  <= WAIT_LOAD;
      r_cmd_idx   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_init_done <= 1'b0;
      r_pcm_tag   <= 1'b0;
      r_pcm_l     <= '0;
      r_pcm_r     <= '0;
      r_uf_cnt    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_cmd_idx   <= w_cmd_idx_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_init_done <= w_init_done_nxt;
      r_pcm_tag   <= w_pcm_tag_nxt;
      r_pcm_l     <= w_pcm_l_nxt;
      r_pcm_r     <= w_pcm_r_nxt;
      r_uf_cnt    <= w_uf_cnt_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge i_bit_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_pcm_l_in, i_pcm_r_in};
    end
  end

  assign o_pcm_ready     = ~w_full;
  assign o_cmd_valid     = r_cmd_valid;
  assign o_cmd_addr      = r_cmd_addr;
  assign o_cmd_data      = r_cmd_data;
  assign o_pcm_tag       = r_pcm_tag;
  assign o_pcm_l_out     = r_pcm_l;
  assign o_pcm_r_out     = r_pcm_r;
  assign o_init_done     = r_init_done;
  assign o_underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_ac97_slot_src.sv
// Testbench for ac97_slot_src: random and directed stimulus against a
// queue-based frame model of the feeder.
module tb_ac97_slot_src;

  localparam int DEPTH = 4;
  localparam int WAITF = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fr = 1'b0;
  logic        pv = 1'b0;
  logic [15:0] pl = '0;
  logic [15:0] pr = '0;
  logic        pcm_ready, cmd_valid, pcm_tag, init_done;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data, pcm_l_out, pcm_r_out;
  logic [7:0]  uf_cnt;

  ac97_slot_src #(.FIFO_DEPTH(DEPTH), .WAIT_FRAMES(WAITF)) dut (
    .i_bit_clk(clk), .i_reset(rst), .i_frame_req(fr),
    .i_pcm_l_in(pl), .i_pcm_r_in(pr), .i_pcm_valid(pv),
    .o_pcm_ready(pcm_ready), .o_cmd_valid(cmd_valid), .o_cmd_addr(cmd_addr),
    .o_cmd_data(cmd_data), .o_pcm_tag(pcm_tag), .o_pcm_l_out(pcm_l_out),
    .o_pcm_r_out(pcm_r_out), .o_init_done(init_done), .o_underflow_cnt(uf_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model
  logic [31:0] m_q[$];
  int          m_frames;
  logic        m_cmd_valid, m_tag, m_init;
  logic [6:0]  m_addr;
  logic [15:0] m_data, m_l, m_r;
  logic [7:0]  m_uf;
  logic [6:0]  tbl_a [3] = '{7'h02, 7'h04, 7'h18};
  logic [15:0] tbl_d [3] = '{16'h0000, 16'h0000, 16'h0808};

  wire [66:0] dut_vec = {cmd_valid, cmd_addr, cmd_data, pcm_tag, pcm_l_out,
                         pcm_r_out, init_done, uf_cnt, pcm_ready};

  function automatic logic [66:0] exp_vec();
    logic rdy;
    rdy = (m_q.size() < DEPTH);
    return {m_cmd_valid, m_addr, m_data, m_tag, m_l, m_r, m_init, m_uf, rdy};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_frames = 0;
    m_cmd_valid = 0; m_tag = 0; m_init = 0;
    m_addr = '0; m_data = '0; m_l = '0; m_r = '0; m_uf = '0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle at edge+1.
  task automatic step(input logic f, input logic v, input logic [15:0] l,
                      input logic [15:0] r);
    int  pre;
    bit  accept;
    int  k;
    logic [31:0] pair;
    pre    = m_q.size();
    accept = v && (pre < DEPTH);
    fr = f; pv = v; pl = l; pr = r;
    @(posedge clk);
    if (f) begin
      m_frames++;
      if (m_frames >= WAITF) begin
        k = m_frames - WAITF;
        if (k < 3) begin
          m_cmd_valid = 1; m_addr = tbl_a[k]; m_data = tbl_d[k];
        end else if (k == 3) begin
          m_cmd_valid = 0; m_addr = '0; m_data = '0; m_init = 1;
        end
        if (pre > 0) begin
          pair = m_q.pop_front();
          m_tag = 1; m_l = pair[31:16]; m_r = pair[15:0];
        end else begin
          m_tag = 0; m_l = '0; m_r = '0;
          if (m_uf != 8'hFF) m_uf = m_uf + 8'd1;
        end
      end
    end
    if (accept) m_q.push_back({l, r});
    #1;
    fr = 0; pv = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
    end
    rst = 0;
  endtask

  task automatic test_init_seq();
    for (int f = 1; f <= WAITF + 3; f++) begin
      repeat ($urandom_range(0, 2)) step(0, 0, 16'h0, 16'h0);
      step(1, 0, 16'h0, 16'h0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL init_frame_%0d: got %h want %h", f, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({cmd_valid, cmd_addr, cmd_data, init_done} !== {1'b0, 7'h00, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL init_done_state: got v=%b a=%h d=%h done=%b want 0/00/0000/1",
               cmd_valid, cmd_addr, cmd_data, init_done);
    end
  endtask

  task automatic test_pcm_order();
    step(0, 1, 16'h1234, 16'hFEDC);
    step(0, 1, 16'h0001, 16'h8000);
    step(1, 0, 16'h0, 16'h0);
    n_cmp++;
    if ({pcm_tag, pcm_l_out, pcm_r_out} !== {1'b1, 16'h1234, 16'hFEDC}) begin
      n_err++;
      $display("FAIL pcm_order_1: got %b %h %h want 1 1234 fedc", pcm_tag, pcm_l_out, pcm_r_out);
    end
    step(1, 0, 16'h0, 16'h0);
    n_cmp++;
    if ({pcm_tag, pcm_l_out, pcm_r_out} !== {1'b1, 16'h0001, 16'h8000}) begin
      n_err++;
      $display("FAIL pcm_order_2: got %b %h %h want 1 0001 8000", pcm_tag, pcm_l_out, pcm_r_out);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] l5, r5;
    l5 = 16'($urandom); r5 = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'($urandom), 16'($urandom));
      n_cmp++;
      if (pcm_ready !== (i < 3)) begin
        n_err++;
        $display("FAIL bp_ready_push%0d: got %b want %b", i + 1, pcm_ready, (i < 3));
      end
    end
    // 5th held while full; pop in same cycle still refuses the push
    step(0, 1, l5, r5);
    step(1, 1, l5, r5);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL bp_pop_while_full: got %h want %h", dut_vec, exp_vec());
    end
    step(0, 1, l5, r5);
    n_cmp++;
    if (pcm_ready !== 1'b0 || m_q.size() != DEPTH) begin
      n_err++;
      $display("FAIL bp_fifth_accepted: got ready %b want 0", pcm_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 16'h0, 16'h0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL bp_drain_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({pcm_l_out, pcm_r_out} !== {l5, r5}) begin
      n_err++;
      $display("FAIL bp_fifth_last: got %h%h want %h%h", pcm_l_out, pcm_r_out, l5, r5);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 1),
           16'($urandom), 16'($urandom));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cyc_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_underflow_sat();
    while (m_q.size() > 0) step(1, 0, 16'h0, 16'h0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 16'h0, 16'h0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL underflow_frame_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({uf_cnt, pcm_tag, pcm_l_out, pcm_r_out} !== {8'hFF, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL underflow_sat: got cnt %0d tag %b want 255 0", uf_cnt, pcm_tag);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) step(0, 1, 16'($urandom_range(1, 65535)), 16'($urandom));
    step(1, 0, 16'h0, 16'h0);
    #2;
    rst = 1;
    #1;
    n_cmp++;
    if (dut_vec !== {1'b0, 7'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_run: got %h want all zero with ready=1", dut_vec);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_wait_push();
    logic [15:0] l1, r1;
    l1 = 16'($urandom); r1 = 16'($urandom);
    step(0, 1, l1, r1);
    step(0, 1, 16'($urandom), 16'($urandom));
    for (int f = 1; f <= WAITF; f++) begin
      step(1, 0, 16'h0, 16'h0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL wait_push_frame_%0d: got %h want %h", f, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({cmd_valid, cmd_addr, pcm_tag, pcm_l_out, pcm_r_out} !== {1'b1, 7'h02, 1'b1, l1, r1}) begin
      n_err++;
      $display("FAIL wait_first_cmd_pop: got %b %h %b %h %h want 1 02 1 %h %h",
               cmd_valid, cmd_addr, pcm_tag, pcm_l_out, pcm_r_out, l1, r1);
    end
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_pcm_order();
    test_backpressure();
    test_random();
    test_underflow_sat();
    test_reset_mid_run();
    test_wait_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
